// File: rtl/pointer_bank_pkg.sv
// Shared constants and helpers for the pointer bank: default geometry,
// derived lane/index widths and the per-register update selector.
package pointer_bank_pkg;

  localparam int AW_DEF   = 16;
  localparam int DW_DEF   = 8;
  localparam int NPTR_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Select fields never collapse to zero width, even for a single lane.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int NLANE = AW_DEF / DW_DEF;
  localparam int IDXW  = clog2(NPTR_DEF);
  localparam int LANEW = clog2(NLANE);

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_WRITE = 2'd1,
    OP_STEP  = 2'd2,
    OP_LOAD  = 2'd3
  } ptr_op_e;

endpackage

// File: rtl/pointer_bank_if.sv
// Control/data bundle between the control unit and the pointer bank.
// inc_dir exists only when POINTER_BANK_DEC_EN is defined.
interface pointer_bank_if
  import pointer_bank_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NPTR = NPTR_DEF
) ();

  localparam int IDXW  = sel_w(NPTR);
  localparam int LANEW = sel_w(AW / DW);

  logic [IDXW-1:0]  addr_sel;
  logic [AW-1:0]    addr;
  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [LANEW-1:0] wr_lane;
  logic [DW-1:0]    wr_data;
  logic             inc_en;
  logic [IDXW-1:0]  inc_idx;
  logic             xchg_en;
  logic [IDXW-1:0]  xchg_a;
  logic [IDXW-1:0]  xchg_b;
  logic [IDXW-1:0]  rd_idx;
  logic [LANEW-1:0] rd_lane;
  logic [DW-1:0]    rd_data;
  logic             inc_wrap;
`ifdef POINTER_BANK_DEC_EN
  logic             inc_dir;
`endif

  modport master (
    output addr_sel, wr_en, wr_idx, wr_lane, wr_data,
    output inc_en, inc_idx, xchg_en, xchg_a, xchg_b,
    output rd_idx, rd_lane,
`ifdef POINTER_BANK_DEC_EN
    output inc_dir,
`endif
    input  addr, rd_data, inc_wrap
  );

  modport slave (
    input  addr_sel, wr_en, wr_idx, wr_lane, wr_data,
    input  inc_en, inc_idx, xchg_en, xchg_a, xchg_b,
    input  rd_idx, rd_lane,
`ifdef POINTER_BANK_DEC_EN
    input  inc_dir,
`endif
    output addr, rd_data, inc_wrap
  );

endinterface

// File: rtl/pointer_bank_reg.sv
// pointer_reg: one AW-bit pointer with byte-lane write, inc/dec step and
// full-word load; priority write > step > load is resolved here.
module pointer_reg
  import pointer_bank_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int LANEW = sel_w(AW_DEF / DW_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [LANEW-1:0] wr_lane,
  input  logic [DW-1:0]    wr_data,
  input  logic             step_en,
  input  logic             step_dn,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_value,
  output logic [AW-1:0]    value,
  output logic             wrap_evt
);

  localparam int NL = AW / DW;

  ptr_op_e       op_s;
  logic [AW-1:0] value_r;
  logic [AW-1:0] nxt_s;
  logic          wrap_s;

  // Decode the winning operation for this edge.
  always_comb begin
    op_s = OP_HOLD;
    if (wr_en) begin
      op_s = OP_WRITE;
    end else if (step_en) begin
      op_s = OP_STEP;
    end else if (ld_en) begin
      op_s = OP_LOAD;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next value and boundary detection; unmatched lanes leave the word intact.
  always_comb begin
    nxt_s  = value_r;
    wrap_s = 1'b0;
    case (op_s)
      OP_WRITE: begin
        for (int l = 0; l < NL; l++) begin
          if (wr_lane == LANEW'(l)) begin
            nxt_s[l*DW +: DW] = wr_data;
          end else begin
            nxt_s[l*DW +: DW] = value_r[l*DW +: DW];
          end
        end
      end
      OP_STEP: begin
        if (step_dn) begin
          nxt_s  = value_r - AW'(1'b1);
          wrap_s = (value_r == {AW{1'b0}});
        end else begin
          nxt_s  = value_r + AW'(1'b1);
          wrap_s = &value_r;
        end
      end
      OP_LOAD: begin
        nxt_s = ld_value;
      end
      default: begin
        nxt_s = value_r;
      end
    endcase
  end

  // Pointer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= {AW{1'b0}};
    end else begin
      value_r <= nxt_s;
    end
  end

  assign value    = value_r;
  assign wrap_evt = wrap_s;

endmodule

// File: rtl/pointer_bank.sv
// pointer_bank: NPTR address pointers with lane load, step, exchange and
// read/address muxing. POINTER_BANK_DEC_EN adds inc_dir (decrement).
module pointer_bank
  import pointer_bank_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NPTR = NPTR_DEF
) (
  input logic          clk,
  input logic          rst,
  pointer_bank_if.slave bus
);

  localparam int IDXW  = sel_w(NPTR);
  localparam int LANEW = sel_w(AW / DW);
  localparam int NL    = AW / DW;

  logic [AW-1:0]   ptr_s [NPTR];
  logic [AW-1:0]   ld_val_s [NPTR];
  logic [NPTR-1:0] wr_hit_s;
  logic [NPTR-1:0] inc_hit_s;
  logic [NPTR-1:0] ld_hit_s;
  logic [NPTR-1:0] wrap_s;
  logic            dir_s;
  logic            xchg_ok_s;
  logic [AW-1:0]   rd_word_s;
  logic [DW-1:0]   rd_data_s;
  logic            inc_wrap_r;

`ifdef POINTER_BANK_DEC_EN
  assign dir_s = bus.inc_dir;
`else
  assign dir_s = 1'b0;
`endif

  // An exchange only happens on an otherwise idle cycle with distinct indices.
  assign xchg_ok_s = bus.xchg_en && !bus.wr_en && !bus.inc_en &&
                     (bus.xchg_a != bus.xchg_b);

  for (genvar i = 0; i < NPTR; i++) begin : g_ptr
    assign wr_hit_s[i]  = bus.wr_en  && (bus.wr_idx  == IDXW'(i));
    assign inc_hit_s[i] = bus.inc_en && (bus.inc_idx == IDXW'(i));
    assign ld_hit_s[i]  = xchg_ok_s &&
                          ((bus.xchg_a == IDXW'(i)) || (bus.xchg_b == IDXW'(i)));
    assign ld_val_s[i]  = (bus.xchg_a == IDXW'(i)) ? ptr_s[bus.xchg_b]
                                                    : ptr_s[bus.xchg_a];

    pointer_reg #(
      .AW    (AW),
      .DW    (DW),
      .LANEW (LANEW)
    ) u_reg (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_hit_s[i]),
      .wr_lane  (bus.wr_lane),
      .wr_data  (bus.wr_data),
      .step_en  (inc_hit_s[i]),
      .step_dn  (dir_s),
      .ld_en    (ld_hit_s[i]),
      .ld_value (ld_val_s[i]),
      .value    (ptr_s[i]),
      .wrap_evt (wrap_s[i])
    );
  end

  // Lane readback; lanes beyond the word read as zero.
  always_comb begin
    rd_word_s = ptr_s[bus.rd_idx];
    rd_data_s = {DW{1'b0}};
    for (int l = 0; l < NL; l++) begin
      if (bus.rd_lane == LANEW'(l)) begin
        rd_data_s = rd_word_s[l*DW +: DW];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  // One-cycle wrap pulse following the step that crossed the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_wrap_r <= 1'b0;
    end else begin
      inc_wrap_r <= |wrap_s;
    end
  end

  assign bus.addr     = ptr_s[bus.addr_sel];
  assign bus.rd_data  = rd_data_s;
  assign bus.inc_wrap = inc_wrap_r;

endmodule

// File: tb/tb_pointer_bank.sv
// Scoreboard bench for pointer_bank (AW=16, DW=8, NPTR=4); decrement cases
// run when POINTER_BANK_DEC_EN is defined.
module tb_pointer_bank;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int NPTR = 4;
  localparam int unsigned MASK = 32'h0000FFFF;

  typedef struct {
    int unsigned addr;
    int unsigned rd;
    bit          wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int unsigned mdl[NPTR];
  int checks = 0;
  int errors = 0;

  pointer_bank_if #(.AW(AW), .DW(DW), .NPTR(NPTR)) bus ();

  pointer_bank #(.AW(AW), .DW(DW), .NPTR(NPTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the model's post-edge view.
  task automatic step(input bit we, input int wi, input int wl, input int wd,
                      input bit ie, input int ii, input bit xe, input int xa,
                      input int xb, input bit dn, input int as, input int ri,
                      input int rl);
    int unsigned nxt[NPTR];
    exp_t e;
    @(negedge clk);
    bus.wr_en    = we;
    bus.wr_idx   = 2'(wi);
    bus.wr_lane  = 1'(wl);
    bus.wr_data  = 8'(wd);
    bus.inc_en   = ie;
    bus.inc_idx  = 2'(ii);
    bus.xchg_en  = xe;
    bus.xchg_a   = 2'(xa);
    bus.xchg_b   = 2'(xb);
    bus.addr_sel = 2'(as);
    bus.rd_idx   = 2'(ri);
    bus.rd_lane  = 1'(rl);
`ifdef POINTER_BANK_DEC_EN
    bus.inc_dir  = dn;
`else
    dn = 1'b0;
`endif
    nxt = mdl;
    e.wrap = 1'b0;
    if (xe && !we && !ie) begin
      nxt[xa] = mdl[xb];
      nxt[xb] = mdl[xa];
    end
    if (ie && !(we && wi == ii)) begin
      if (dn) begin
        e.wrap  = (mdl[ii] == 0);
        nxt[ii] = (mdl[ii] + MASK) & MASK;
      end else begin
        e.wrap  = (mdl[ii] == MASK);
        nxt[ii] = (mdl[ii] + 1) & MASK;
      end
    end
    if (we) begin
      nxt[wi] = (mdl[wi] & ~(32'hFF << (8 * wl))) | ((wd & 32'hFF) << (8 * wl));
    end
    mdl = nxt;
    e.addr = mdl[as];
    e.rd   = (mdl[ri] >> (8 * rl)) & 32'hFF;
    exp_q.push_back(e);
  endtask

  task automatic load(input int idx, input int unsigned val);
    step(1'b1, idx, 0, int'(val & 32'hFF), 1'b0, 0, 1'b0, 0, 0, 1'b0, idx, idx, 0);
    step(1'b1, idx, 1, int'((val >> 8) & 32'hFF), 1'b0, 0, 1'b0, 0, 0, 1'b0, idx, idx, 1);
  endtask

  // Literal check of the state produced by the edge following the last step.
  task automatic dchk(input string name, input int unsigned ea, input int unsigned er,
                      input bit ew);
    @(posedge clk);
    #2;
    chk({name, "_addr"}, bus.addr, ea);
    chk({name, "_rd"}, bus.rd_data, er);
    chk({name, "_wrap"}, bus.inc_wrap, ew);
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_idx = 2'd0; bus.wr_lane = 1'b0; bus.wr_data = 8'd0;
    bus.inc_en = 1'b0; bus.inc_idx = 2'd0; bus.xchg_en = 1'b0;
    bus.xchg_a = 2'd0; bus.xchg_b = 2'd0;
    bus.addr_sel = 2'd0; bus.rd_idx = 2'd0; bus.rd_lane = 1'b0;
`ifdef POINTER_BANK_DEC_EN
    bus.inc_dir = 1'b0;
`endif
  endtask

  task automatic reset_check(input string name);
    for (int s = 0; s < NPTR; s++) begin
      bus.addr_sel = 2'(s);
      bus.rd_idx   = 2'(s);
      #1;
      chk({name, "_addr"}, bus.addr, 0);
      chk({name, "_rd"}, bus.rd_data, 0);
    end
    chk({name, "_wrap"}, bus.inc_wrap, 0);
  endtask

  // Monitor: every post-edge sample with an outstanding expectation is scored.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_addr", bus.addr, e.addr);
        chk("sb_rd", bus.rd_data, e.rd);
        chk("sb_wrap", bus.inc_wrap, e.wrap);
      end
    end
  end

  initial begin
    int drain;
    idle_inputs();
    for (int i = 0; i < NPTR; i++) mdl[i] = 0;
    #2;
    reset_check("rst_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load(1, 32'h1234);
    dchk("wr_ptr1", 32'h1234, 32'h12, 1'b0);

    // Asynchronous reset between edges with ptr1 loaded.
    @(negedge clk);
    #2;
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < NPTR; i++) mdl[i] = 0;
    reset_check("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load(0, 32'hFFFF);
    step(1'b0, 0, 0, 0, 1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0, 1);
    dchk("inc_wrap", 32'h0000, 32'h00, 1'b1);
    step(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
    dchk("wrap_end", 32'h0000, 32'h00, 1'b0);
    load(0, 32'h0041);
    step(1'b0, 0, 0, 0, 1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
    dchk("inc_plain", 32'h0042, 32'h42, 1'b0);

    load(2, 32'h10FF);
    step(1'b1, 2, 0, 8'hAA, 1'b1, 2, 1'b0, 0, 0, 1'b0, 2, 2, 0);
    dchk("wr_beats_inc", 32'h10AA, 32'hAA, 1'b0);
    load(0, 32'h0007);
    step(1'b1, 1, 0, 8'h55, 1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 1, 0);
    dchk("wr_inc_split", 32'h0008, 32'h55, 1'b0);

    load(0, 32'h1111);
    load(3, 32'h3333);
    step(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 0, 3, 1'b0, 0, 3, 1);
    dchk("xchg", 32'h3333, 32'h11, 1'b0);
    step(1'b1, 1, 1, 8'h77, 1'b0, 0, 1'b1, 0, 3, 1'b0, 0, 1, 1);
    dchk("xchg_blocked_wr", 32'h3333, 32'h77, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1, 1'b1, 1, 2, 1'b0, 2, 1, 0);
    step(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 2, 2, 1'b0, 2, 2, 1);

`ifdef POINTER_BANK_DEC_EN
    load(2, 32'h0000);
    step(1'b0, 0, 0, 0, 1'b1, 2, 1'b0, 0, 0, 1'b1, 2, 2, 1);
    dchk("dec_wrap", 32'hFFFF, 32'hFF, 1'b1);
`endif

    for (int n = 0; n < 600; n++) begin
      bit we, ie, xe, dn;
      int wd;
      we = ($urandom_range(0, 2) == 0);
      ie = ($urandom_range(0, 1) == 0);
      xe = ($urandom_range(0, 2) == 0);
`ifdef POINTER_BANK_DEC_EN
      dn = ($urandom_range(0, 1) == 0);
`else
      dn = 1'b0;
`endif
      case ($urandom_range(0, 3))
        0:       wd = 8'hFF;
        1:       wd = 8'h00;
        default: wd = int'($urandom_range(0, 255));
      endcase
      step(we, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), wd,
           ie, int'($urandom_range(0, 3)), xe, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), dn, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pointer_bank.md
Name: pointer_bank

Overview:
- Parametrised successor to the two-entry IP/DP pointer pair in the 8-bit CPU.
- Holds NPTR address pointers of AW bits each. Pointers are loaded byte-lane-wise from the internal data bus and read back one lane at a time to the ALU side.
- One pointer at a time drives the address bus. Supports per-cycle increment with a wrap pulse, and a single-cycle exchange of two pointers, which generalises the old IP/DP swap toggle.
- Sits between the control unit, the internal data bus and the memory address bus.

Parameters:
- AW, 16, pointer/address width; must be a multiple of DW.
- DW, 8, data bus width (byte-lane width).
- NPTR, 4, number of pointers; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr_sel  input  clog2(NPTR)  index of the pointer driving addr.
- addr  output  AW  contents of pointer[addr_sel], combinational.
- wr_en  input  1  load one byte lane.
- wr_idx  input  clog2(NPTR)  pointer to load.
- wr_lane  input  clog2(AW/DW)  byte lane to load; lane 0 is the LSB.
- wr_data  input  DW  data to load.
- inc_en  input  1  increment pointer[inc_idx].
- inc_idx  input  clog2(NPTR)  pointer to increment.
- xchg_en  input  1  exchange two pointers.
- xchg_a  input  clog2(NPTR)  first exchange index.
- xchg_b  input  clog2(NPTR)  second exchange index.
- rd_idx  input  clog2(NPTR)  pointer for readback.
- rd_lane  input  clog2(AW/DW)  lane for readback.
- rd_data  output  DW  lane rd_lane of pointer[rd_idx], combinational.
- inc_wrap  output  1  registered one-cycle pulse after an increment wraps.
- inc_dir  input  1  0 = increment, 1 = decrement; present only with POINTER_BANK_DEC_EN.

Behaviour:
- Reset: rst is asynchronous, active-high. All pointers are 0, inc_wrap is 0; addr and rd_data therefore read 0 immediately. Reset asserted mid-operation discards any in-flight update. First update occurs on the first rising clk edge after rst deasserts.
- Write: on the edge with wr_en=1, lane wr_lane of pointer[wr_idx] takes wr_data; other lanes hold. Result is visible on addr/rd_data after that edge (latency 1).
- Increment: on the edge with inc_en=1, pointer[inc_idx] becomes (value+1) mod 2^AW.
  - If the old value was all-ones, inc_wrap=1 for exactly the following cycle; otherwise inc_wrap=0.
- Concurrent write and increment:
  - Different pointers: both take effect in the same cycle.
  - Same pointer: the write wins, the increment is dropped, and inc_wrap=0.
- Exchange: on the edge with xchg_en=1, and only if wr_en=0 and inc_en=0, pointer[xchg_a] and pointer[xchg_b] swap, using pre-edge values.
  - xchg_a==xchg_b is a no-op.
  - xchg_en together with wr_en or inc_en is ignored entirely.
- Priority per pointer: write > increment > exchange.
- Out-of-range lane indices (only possible when AW/DW is not a power of two): writes are ignored and rd_data reads 0.
- No internal state machine beyond the registers; all outputs other than inc_wrap are combinational views of the registers.

Optional Feature:
- POINTER_BANK_DEC_EN defined:
  - inc_dir port exists. With inc_dir=1, an inc_en cycle decrements, mod 2^AW.
  - inc_wrap pulses when the old value was 0. All priority rules are unchanged.
- Undefined: inc_dir port is absent and inc_en always increments.

Decomposition:
- Shared package pointer_bank_pkg:
  - Default AW/DW/NPTR constants.
  - Derived constants NLANE=AW/DW, IDXW=clog2(NPTR), LANEW=clog2(NLANE).
  - A clog2 helper function.
- One natural sub-module, pointer_reg: a single AW-bit register with async active-high reset, byte-lane load, inc/dec, and a wrap output. pointer_bank instantiates NPTR of these and adds the priority, exchange and read/address muxing.

Test Plan (AW=16, DW=8, NPTR=4):
- Pulse rst mid-run with pointer1=0x1234 -> addr=0x0000 immediately for every addr_sel; rd_data=0x00; inc_wrap=0.
- Write ptr1 lane0=0x34, then lane1=0x12; set addr_sel=1, rd_idx=1, rd_lane=1 -> addr=0x1234, rd_data=0x12.
- Load ptr0=0xFFFF, inc_en with inc_idx=0 -> next cycle addr=0x0000, inc_wrap=1 for one cycle then 0. Increment 0x0041 -> 0x0042 with no pulse.
- Same cycle, ptr2=0x10FF: wr ptr2 lane0=0xAA plus inc ptr2 -> ptr2=0x10AA, inc_wrap=0. Same cycle, wr ptr1 lane0=0x55 plus inc ptr0 from 0x0007 -> ptr1 lane0=0x55, ptr0=0x0008.
- ptr0=0x1111, ptr3=0x3333; xchg 0/3 -> ptr0=0x3333, ptr3=0x1111. Repeat the exchange with wr_en=1 -> no swap, only the write applies.
- With POINTER_BANK_DEC_EN: ptr2=0x0000, inc_dir=1, inc_en -> ptr2=0xFFFF, inc_wrap pulses once.
